// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side handshake and pipeline-control bundle for pipe_hazard_ctrl.
// Perf-counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if #(parameter int AW = 5);
    logic          i_valid;
    logic [AW-1:0] i_RA1;
    logic [AW-1:0] i_RA2;
    logic          i_use1;
    logic          i_use2;
    logic          i_WE;
    logic [AW-1:0] i_WA;
    logic          i_mem;
    logic          i_mem_ready;
    logic          o_stall;
    logic          o_bubble;
    logic          o_b1_en;
    logic          o_b2_en;
    logic          o_mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   o_cyc_cnt;
    logic [31:0]   o_raw_stall_cnt;
    logic [31:0]   o_mem_wait_cnt;

    modport master (
        output i_valid, i_RA1, i_RA2, i_use1, i_use2, i_WE, i_WA, i_mem, i_mem_ready,
        input  o_stall, o_bubble, o_b1_en, o_b2_en, o_mem_err,
        input  o_cyc_cnt, o_raw_stall_cnt, o_mem_wait_cnt
    );
    modport slave (
        input  i_valid, i_RA1, i_RA2, i_use1, i_use2, i_WE, i_WA, i_mem, i_mem_ready,
        output o_stall, o_bubble, o_b1_en, o_b2_en, o_mem_err,
        output o_cyc_cnt, o_raw_stall_cnt, o_mem_wait_cnt
    );
`else
    modport master (
        output i_valid, i_RA1, i_RA2, i_use1, i_use2, i_WE, i_WA, i_mem, i_mem_ready,
        input  o_stall, o_bubble, o_b1_en, o_b2_en, o_mem_err
    );
    modport slave (
        input  i_valid, i_RA1, i_RA2, i_use1, i_use2, i_WE, i_WA, i_mem, i_mem_ready,
        output o_stall, o_bubble, o_b1_en, o_b2_en, o_mem_err
    );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// RAW-hazard stall / bubble sequencer and memory-wait freeze for a 5-stage pipe.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int AW          = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RST,
    pipe_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] wa;
        logic          mem;
    } shadow_t;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    shadow_t    ex_q, mem_q;
    state_t     state;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic       mem_err_q;
    logic       hz, frz;
    logic       m1, m2;

    // Register 0 never aliases a real producer, so it is excluded from matching.
    function automatic logic match(input logic [AW-1:0] x, input shadow_t e, input shadow_t m);
        return (x != '0) && ((e.v && e.we && e.wa == x) || (m.v && m.we && m.wa == x));
    endfunction

    always_comb begin
        m1      = bus.i_valid & bus.i_use1 & match(bus.i_RA1, ex_q, mem_q);
        m2      = bus.i_valid & bus.i_use2 & match(bus.i_RA2, ex_q, mem_q);
        hz      = m1 | m2;
        frz     = (state == S_ERR) ||
                  (mem_q.v && mem_q.mem && !bus.i_mem_ready);
        cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end

    assign bus.o_b1_en   = ~frz;
    assign bus.o_b2_en   = ~frz;
    assign bus.o_stall   = hz | frz;
    assign bus.o_bubble  = hz & ~frz;
    assign bus.o_mem_err = mem_err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_q      <= '0;
            mem_q     <= '0;
            state     <= S_RUN;
            cnt       <= '0;
            mem_err_q <= 1'b0;
        end else begin
            if (!frz) begin
                mem_q <= ex_q;
                ex_q  <= hz ? '0 : {bus.i_valid, bus.i_WE, bus.i_WA, bus.i_mem};
            end
            case (state)
                S_RUN: begin
                    if (frz) begin
                        cnt <= 8'd1;
                        // A one-cycle budget expires on the very first wait edge.
                        if (TIMEOUT == 8'd1) begin
                            state     <= S_ERR;
                            mem_err_q <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.i_mem_ready) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == TIMEOUT) begin
                            state     <= S_ERR;
                            mem_err_q <= 1'b1;
                        end
                    end
                end
                S_ERR:   mem_err_q <= 1'b1;
                default: state <= S_RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cyc_cnt, raw_cnt, wait_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cyc_cnt  <= '0;
            raw_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (hz && !frz)
                raw_cnt <= raw_cnt + 32'd1;
            if (frz && state != S_ERR)
                wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign bus.o_cyc_cnt       = cyc_cnt;
    assign bus.o_raw_stall_cnt = raw_cnt;
    assign bus.o_mem_wait_cnt  = wait_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, RAW stalls, r0/unused-source, memory freeze, timeout.
module tb_pipe_hazard_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl_if #(.AW(5)) bus ();

    pipe_hazard_ctrl #(.AW(5), .MEM_TIMEOUT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // {stall, bubble, b1_en, b2_en, mem_err}
    function automatic logic [4:0] outs();
        return {bus.o_stall, bus.o_bubble, bus.o_b1_en, bus.o_b2_en, bus.o_mem_err};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic u1, input logic u2, input logic we, input logic [4:0] wa,
                       input logic m, input logic rdy);
        bus.i_valid = v;  bus.i_RA1 = ra1; bus.i_RA2 = ra2;
        bus.i_use1  = u1; bus.i_use2 = u2; bus.i_WE  = we;
        bus.i_WA    = wa; bus.i_mem  = m;  bus.i_mem_ready = rdy;
        #2;
    endtask

    task automatic flush();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drv(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            tick();
            #1;
            n_cmp++;
            if (outs() !== 5'b00110) begin
                n_bad++;
                $display("FAIL reset_%0d outs got %b want %b", i, outs(), 5'b00110);
            end
        end
        RST = 1'b0;
        flush();
    endtask

    task automatic test_raw_back_to_back();
        logic [4:0] exp [0:3] = '{5'b00110, 5'b11110, 5'b11110, 5'b00110};
        drv(1, 0, 0, 0, 0, 1, 5, 0, 0);
        n_cmp++;
        if (outs() !== exp[0]) begin n_bad++; $display("FAIL b2b_writer outs got %b want %b", outs(), exp[0]); end
        tick();
        drv(1, 5, 0, 1, 0, 1, 6, 0, 0);
        for (int c = 1; c < 4; c++) begin
            n_cmp++;
            if (outs() !== exp[c]) begin n_bad++; $display("FAIL b2b_cyc%0d outs got %b want %b", c, outs(), exp[c]); end
            tick();
            #2;
        end
        flush();
    endtask

    task automatic test_raw_gap();
        drv(1, 0, 0, 0, 0, 1, 5, 0, 0);
        tick();
        drv(1, 1, 0, 1, 0, 1, 6, 0, 0);
        n_cmp++;
        if (outs() !== 5'b00110) begin n_bad++; $display("FAIL gap_indep outs got %b want %b", outs(), 5'b00110); end
        tick();
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (outs() !== 5'b11110) begin n_bad++; $display("FAIL gap_stall outs got %b want %b", outs(), 5'b11110); end
        tick();
        #2;
        n_cmp++;
        if (outs() !== 5'b00110) begin n_bad++; $display("FAIL gap_issue outs got %b want %b", outs(), 5'b00110); end
        tick();
        flush();
    endtask

    task automatic test_r0();
        drv(1, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        drv(1, 0, 0, 1, 1, 0, 0, 0, 0);
        n_cmp++;
        if (outs() !== 5'b00110) begin n_bad++; $display("FAIL r0_reader outs got %b want %b", outs(), 5'b00110); end
        tick();
        flush();
    endtask

    task automatic test_unused_src();
        drv(1, 0, 0, 0, 0, 1, 7, 0, 0);
        tick();
        drv(1, 7, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (outs() !== 5'b00110) begin n_bad++; $display("FAIL unused_ra1 outs got %b want %b", outs(), 5'b00110); end
        drv(1, 7, 7, 0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (outs() !== 5'b11110) begin n_bad++; $display("FAIL used_ra2 outs got %b want %b", outs(), 5'b11110); end
        flush();
    endtask

    task automatic test_mem_wait();
        drv(1, 0, 0, 0, 0, 1, 3, 1, 0);
        tick();
        drv(1, 0, 0, 0, 0, 1, 9, 0, 0);
        tick();
        // reader of r9 while the load sits in MEM with ready low
        drv(1, 9, 0, 1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (outs() !== 5'b10000) begin n_bad++; $display("FAIL memwait_frz%0d outs got %b want %b", c, outs(), 5'b10000); end
            tick();
            #2;
        end
        drv(1, 9, 0, 1, 0, 0, 0, 0, 1);
        n_cmp++;
        if (outs() !== 5'b11110) begin n_bad++; $display("FAIL memwait_ready outs got %b want %b", outs(), 5'b11110); end
        tick();
        drv(1, 9, 0, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (outs() !== 5'b11110) begin n_bad++; $display("FAIL memwait_mem_dep outs got %b want %b", outs(), 5'b11110); end
        tick();
        #2;
        n_cmp++;
        if (outs() !== 5'b00110) begin n_bad++; $display("FAIL memwait_issue outs got %b want %b", outs(), 5'b00110); end
        tick();
        flush();
    endtask

    task automatic test_timeout();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int c = 0; c < 4; c++) begin
            #2;
            n_cmp++;
            if (outs() !== 5'b10000) begin n_bad++; $display("FAIL tmo_wait%0d outs got %b want %b", c, outs(), 5'b10000); end
            tick();
        end
        #2;
        n_cmp++;
        if (outs() !== 5'b10001) begin n_bad++; $display("FAIL tmo_err outs got %b want %b", outs(), 5'b10001); end
        drv(1, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        #2;
        n_cmp++;
        if (outs() !== 5'b10001) begin n_bad++; $display("FAIL tmo_sticky outs got %b want %b", outs(), 5'b10001); end
        RST = 1'b1;
        tick();
        #2;
        n_cmp++;
        if (outs() !== 5'b00110) begin n_bad++; $display("FAIL tmo_rst outs got %b want %b", outs(), 5'b00110); end
        RST = 1'b0;
        flush();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_raw_back_to_back();
        test_raw_gap();
        test_r0();
        test_unused_src();
        test_mem_wait();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
